// File: rtl/sigma_arbiter.sv
// sigma_arbiter: round-robin front end for a shared two-stage rotate-XOR unit
// that computes ROTR(x,a) ^ ROTR(x,b) ^ ROTR(x,c).
// Each request picks one of two programmable rotation sets.
// Responses come back in order and carry the id of the requester.
// Optional statistics counters are built when SIGMA_ARB_STATS_EN is defined;
// without it, stat_ops and stat_stall are tied to zero.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. req_ready never depends on req_data, and rsp_valid stays high with
// rsp_id/rsp_data stable until rsp_ready accepts the result.
module sigma_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_sel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic [4:0]                cfg_wdata,
    output logic [31:0]               stat_ops,
    output logic [31:0]               stat_stall
);

    // Entry 0 is amount a, entry 1 is b, entry 2 is c.
    localparam logic [2:0][4:0] SET0_RST = {5'd22, 5'd13, 5'd2};
    localparam logic [2:0][4:0] SET1_RST = {5'd25, 5'd11, 5'd6};

    // Rotating the doubled word makes n = 0 come out as the identity.
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [4:0] n);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} >> n;
        return dbl[DATA_W-1:0];
    endfunction

    logic [2:0][4:0]   set0_q, set0_d, set1_q, set1_d;
    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_x_q, s1_x_d;
    logic [2:0][4:0]   s1_amt_q, s1_amt_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              s2_v_q, s2_v_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              stall;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand;
    logic              accept;
    logic [DATA_W-1:0] sigma_result;

    assign stall        = s2_v_q & ~rsp_ready;
    assign accept       = grant_found & ~stall & rst;
    assign sigma_result = rotr(s1_x_q, s1_amt_q[0]) ^ rotr(s1_x_q, s1_amt_q[1]) ^ rotr(s1_x_q, s1_amt_q[2]);

    assign rsp_valid = s2_v_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_data_q;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Only the granted requester sees ready, and only while S1 can move.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Config writes; addresses 3 and 7 are dropped.
    always_comb begin
        set0_d = set0_q;
        set1_d = set1_q;
        if (cfg_we && cfg_addr[1:0] != 2'd3) begin
            if (cfg_addr[2]) begin
                set1_d[cfg_addr[1:0]] = cfg_wdata;
            end else begin
                set0_d[cfg_addr[1:0]] = cfg_wdata;
            end
        end
    end

    // Pipeline advance: S1 moves into S2 and the grant loads S1, unless S2 is stalled.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_x_d    = s1_x_q;
        s1_amt_d  = s1_amt_q;
        s1_id_d   = s1_id_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_id_d   = s2_id_q;
        ptr_d     = ptr_q;
        if (!stall) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_data_d = sigma_result;
                s2_id_d   = s1_id_q;
            end
            s1_v_d = accept;
            if (accept) begin
                s1_x_d   = req_data[grant_idx*DATA_W +: DATA_W];
                // Amounts are latched here, so later config writes cannot disturb this op.
                s1_amt_d = req_sel[grant_idx] ? set1_q : set0_q;
                s1_id_d  = grant_idx;
                ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set0_q    <= SET0_RST;
            set1_q    <= SET1_RST;
            s1_v_q    <= 1'b0;
            s1_x_q    <= '0;
            s1_amt_q  <= '0;
            s1_id_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
            ptr_q     <= '0;
        end else begin
            set0_q    <= set0_d;
            set1_q    <= set1_d;
            s1_v_q    <= s1_v_d;
            s1_x_q    <= s1_x_d;
            s1_amt_q  <= s1_amt_d;
            s1_id_q   <= s1_id_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_id_q   <= s2_id_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef SIGMA_ARB_STATS_EN
    logic [31:0] ops_q, ops_d, stall_cnt_q, stall_cnt_d;

    // Free-running wrap-around counters of accepts and stall cycles.
    always_comb begin
        ops_d       = ops_q + (accept ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ops_q       <= ops_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_ops   = ops_q;
    assign stat_stall = stall_cnt_q;
`else
    assign stat_ops   = '0;
    assign stat_stall = '0;
`endif

endmodule
